// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush control for the F/D/E/M pipeline registers
//
// Purpose
//   Drives the enable (advance) and clear (bubble) pins of the pipeline
//   registers. It resolves three kinds of hazard:
//     - taken-branch redirects, which flush Decode and Execute
//     - multi-cycle MDU (mult/div) ops, which freeze the pipeline for
//       MDU_LAT cycles using a small FSM and a wait counter
//     - load-use hazards, which stall Fetch/Decode and bubble Execute
//   for one cycle
//
// Optional feature
//   HAZ_PERF_CNT_EN : when defined, builds a 32-bit counter of cycles with
//                     en_F==0. When undefined, stall_cycles reads 0.
//
// Parameters
//   REG_ADDR_W : register-file address width
//   MDU_LAT    : total freeze cycles per MDU op, start cycle included
//                (legal range 1..2**CNT_W)
//   CNT_W      : MDU wait counter width
//
// Ports
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   rs_D, rt_D          source registers of the instruction in Decode
//   rt_E                destination of the load in Execute
//   mem_to_reg_E        the instruction in Execute is a load
//   branch_taken_E      branch/jump resolved taken in Execute
//   mdu_start_E         MDU op enters Execute (1-cycle pulse)
//   en_F, en_D, en_E    pipeline register enables (1 = advance)
//   clr_D, clr_E, clr_M pipeline register clears (1 = bubble)
//   mdu_busy            FSM is in MDU_WAIT
//   err_conflict        sticky: branch and MDU start were seen in the same cycle
//   stall_cycles        performance counter of stalled fetch cycles

module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MDU_LAT    = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_D,
    input  logic [REG_ADDR_W-1:0] rt_D,
    input  logic [REG_ADDR_W-1:0] rt_E,
    input  logic                  mem_to_reg_E,
    input  logic                  branch_taken_E,
    input  logic                  mdu_start_E,
    output logic                  en_F,
    output logic                  en_D,
    output logic                  en_E,
    output logic                  clr_D,
    output logic                  clr_E,
    output logic                  clr_M,
    output logic                  mdu_busy,
    output logic                  err_conflict,
    output logic [31:0]           stall_cycles
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MDU_WAIT = 1'b1;

    // The start cycle is spent in RUN, so the wait state covers MDU_LAT-1
    // cycles; cnt counts down to 0 and the last wait cycle is cnt==0.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (MDU_LAT > 1) ? CNT_W'(MDU_LAT - 2) : '0;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;

    // Register 0 is hard-wired to zero, so a load into it creates no hazard.
    assign load_use = mem_to_reg_E && (rt_E != '0) &&
                      ((rt_E == rs_D) || (rt_E == rt_D));

    always_comb begin
        en_F     = 1'b1;
        en_D     = 1'b1;
        en_E     = 1'b1;
        clr_D    = 1'b0;
        clr_E    = 1'b0;
        clr_M    = 1'b0;
        mdu_busy = 1'b0;
        // While rst_n is low the outputs keep their idle values, so a
        // reset arriving mid-wait releases the pipeline at once.
        if (rst_n) begin
            if (state == MDU_WAIT) begin
                // Execute is frozen, so any other request is ignored.
                en_F     = 1'b0;
                en_D     = 1'b0;
                en_E     = 1'b0;
                clr_M    = 1'b1;
                mdu_busy = 1'b1;
            end else if (branch_taken_E) begin
                // Flushing Decode also removes any load-use dependent.
                clr_D = 1'b1;
                clr_E = 1'b1;
            end else if (mdu_start_E) begin
                en_F  = 1'b0;
                en_D  = 1'b0;
                en_E  = 1'b0;
                clr_M = 1'b1;
            end else if (load_use) begin
                en_F  = 1'b0;
                en_D  = 1'b0;
                clr_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            cnt          <= '0;
            err_conflict <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken_E) begin
                        // The redirect wins; a simultaneous MDU start is dropped.
                        if (mdu_start_E) begin
                            err_conflict <= 1'b1;
                        end
                    end else if (mdu_start_E && (MDU_LAT > 1)) begin
                        state <= MDU_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!en_F) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int MDU_LAT    = 4;
    localparam int CNT_W      = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [REG_ADDR_W-1:0] rs_D, rt_D, rt_E;
    logic                  mem_to_reg_E, branch_taken_E, mdu_start_E;
    logic                  en_F, en_D, en_E, clr_D, clr_E, clr_M;
    logic                  mdu_busy, err_conflict;
    logic [31:0]           stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (REG_ADDR_W),
        .MDU_LAT    (MDU_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rs_D           (rs_D),
        .rt_D           (rt_D),
        .rt_E           (rt_E),
        .mem_to_reg_E   (mem_to_reg_E),
        .branch_taken_E (branch_taken_E),
        .mdu_start_E    (mdu_start_E),
        .en_F           (en_F),
        .en_D           (en_D),
        .en_E           (en_E),
        .clr_D          (clr_D),
        .clr_E          (clr_E),
        .clr_M          (clr_M),
        .mdu_busy       (mdu_busy),
        .err_conflict   (err_conflict),
        .stall_cycles   (stall_cycles)
    );

    typedef struct packed {
        logic [7:0]  ctl;   // {en_F,en_D,en_E,clr_D,clr_E,clr_M,mdu_busy,err_conflict}
        logic [31:0] stall;
        logic [31:0] id;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int n_issued = 0;

    // Reference model: remaining frozen cycles after the current one,
    // sticky error flag and stall tally.
    int          m_left  = 0;
    logic        m_err   = 1'b0;
    logic [31:0] m_stall = 32'd0;

    task automatic step(input logic rst, input int rs, input int rt, input int rte,
                        input logic ld, input logic br, input logic mdu);
        exp_t e;
        logic ef, ed, ee, cd, ce, cm, bz, lu;
        @(posedge clk);
        #1;
        rst_n          = rst;
        rs_D           = REG_ADDR_W'(rs);
        rt_D           = REG_ADDR_W'(rt);
        rt_E           = REG_ADDR_W'(rte);
        mem_to_reg_E   = ld;
        branch_taken_E = br;
        mdu_start_E    = mdu;

        lu = ld && (rte != 0) && (rte == rs || rte == rt);
        {ef, ed, ee, cd, ce, cm, bz} = 7'b1110000;
        if (rst) begin
            if (m_left > 0) begin
                {ef, ed, ee, cm, bz} = 5'b00011;
            end else if (br) begin
                {cd, ce} = 2'b11;
            end else if (mdu) begin
                {ef, ed, ee, cm} = 4'b0001;
            end else if (lu) begin
                {ef, ed, ce} = 3'b001;
            end
        end
        e.ctl = {ef, ed, ee, cd, ce, cm, bz, m_err};
`ifdef HAZ_PERF_CNT_EN
        e.stall = m_stall;
`else
        e.stall = 32'd0;
`endif
        e.id = n_issued;
        n_issued++;
        exp_q.push_back(e);

        if (!rst) begin
            m_left  = 0;
            m_err   = 1'b0;
            m_stall = 32'd0;
        end else begin
            if (!ef) m_stall = m_stall + 32'd1;
            if (m_left > 0) begin
                m_left--;
            end else if (br) begin
                if (mdu) m_err = 1'b1;
            end else if (mdu) begin
                m_left = MDU_LAT - 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1, 2, 3, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {en_F, en_D, en_E, clr_D, clr_E, clr_M, mdu_busy, err_conflict};
            n_vec++;
            if (got !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl vec %0d: got %b want %b (en_F,en_D,en_E,clr_D,clr_E,clr_M,busy,err)",
                         e.id, got, e.ctl);
            end
            n_vec++;
            if (stall_cycles !== e.stall) begin
                n_bad++;
                $display("FAIL stall_cycles vec %0d: got %0d want %0d", e.id, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        rst_n = 1'b0; rs_D = '0; rt_D = '0; rt_E = '0;
        mem_to_reg_E = 1'b0; branch_taken_E = 1'b0; mdu_start_E = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // T1 load-use, then rt_E=0 gives no stall, rt match also counts
        step(1'b1, 8, 3, 8, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8, 3, 0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4, 9, 9, 1'b1, 1'b0, 1'b0);
        idle(1);
        // T3 MDU op, then T6 counter value is visible in idle cycles
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(5);
        // T2 branch over load-use
        step(1'b1, 8, 3, 8, 1'b1, 1'b1, 1'b0);
        // Back-to-back MDU ops with a load-use ignored during the wait
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8, 3, 8, 1'b1, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(5);
        // T4 reset two cycles into an MDU op
        step(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 8, 3, 8, 1'b1, 1'b0, 1'b1);
        idle(3);
        // T5 conflict, sticky until reset
        step(1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        idle(3);
        step(1'b1, 8, 3, 8, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) >= 2),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 12));
        end
        idle(2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
